// File: rtl/game_countdown.sv
// Game countdown timer: M:SS BCD count, decremented by a 1 s strobe.
// States IDLE / RUN / PAUSED / DONE; every output is a flop.
// Optional feature: define GAME_COUNTDOWN_WARN_EN to enable the
// low-time warning output. When it is undefined, warn is tied low.
module game_countdown #(
  parameter int INIT_MIN = 3,
  parameter int INIT_SEC = 0,
  parameter int WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       warn
);

  localparam logic [3:0] INIT_M    = 4'(INIT_MIN);
  localparam logic [3:0] INIT_T    = 4'(INIT_SEC / 10);
  localparam logic [3:0] INIT_O    = 4'(INIT_SEC % 10);
  localparam bit         INIT_ZERO = (INIT_MIN == 0) && (INIT_SEC == 0);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t     state, state_n;
  logic [3:0] min_n, tens_n, ones_n;
  logic [3:0] dec_m, dec_t, dec_o;
  logic       expired_n;
  logic       at_one;

  // One-second BCD decrement with borrow; digits wrap within BCD range.
  always_comb begin
    dec_m = min_bcd;
    dec_t = sec_tens;
    dec_o = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_o = 4'd9;
      if (sec_tens == 4'd0) begin
        dec_t = 4'd5;
        dec_m = min_bcd - 4'd1;
      end else begin
        dec_t = sec_tens - 4'd1;
      end
    end
  end

  assign at_one = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Next-state and next-count logic; start wins over pause outside RUN.
  always_comb begin
    state_n   = state;
    min_n     = min_bcd;
    tens_n    = sec_tens;
    ones_n    = sec_ones;
    expired_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          min_n  = INIT_M;
          tens_n = INIT_T;
          ones_n = INIT_O;
          if (INIT_ZERO) begin
            state_n = DONE;
            // Repeated start with a zero load must not stretch the pulse.
            expired_n = !expired;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (tick_1s) begin
          min_n  = dec_m;
          tens_n = dec_t;
          ones_n = dec_o;
          if (at_one) begin
            state_n   = DONE;
            expired_n = 1'b1;
          end else if (pause) begin
            state_n = PAUSED;
          end
        end else if (pause) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (start || pause) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, count and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      min_bcd  <= INIT_M;
      sec_tens <= INIT_T;
      sec_ones <= INIT_O;
      running  <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_n;
      min_bcd  <= min_n;
      sec_tens <= tens_n;
      sec_ones <= ones_n;
      running  <= (state_n == RUN);
      done     <= (state_n == DONE);
      expired  <= expired_n;
    end
  end

`ifdef GAME_COUNTDOWN_WARN_EN
  logic [9:0] total_n;
  logic       warn_n;

  // Warning computed from the next count so it moves with the display.
  always_comb begin
    total_n = {6'd0, min_n} * 10'd60 + {6'd0, tens_n} * 10'd10 + {6'd0, ones_n};
    warn_n  = ((state_n == RUN) || (state_n == PAUSED)) &&
              (total_n != 10'd0) && (total_n <= 10'(WARN_SEC));
  end

  // Registered warning flag.
  always_ff @(posedge clk) begin
    if (rst) warn <= 1'b0;
    else     warn <= warn_n;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_countdown.sv
// Scoreboard bench for game_countdown: four instances with different
// load values share one clock; the driver queues expected outputs per
// cycle and a negedge monitor pops and compares them.
module tb_game_countdown;

  typedef struct {
    int         id;
    int         cyc;
    logic [3:0] m, t, o;
    logic       r, d, x, w;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst, start, pause, tick;
  logic [3:0] mb [4];
  logic [3:0] st [4];
  logic [3:0] so [4];
  logic [3:0] run_o, done_o, exp_o, warn_o;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  game_countdown #(.INIT_MIN(0), .INIT_SEC(12), .WARN_SEC(10)) u0 (
    .clk(clk), .rst(rst[0]), .tick_1s(tick[0]), .start(start[0]), .pause(pause[0]),
    .min_bcd(mb[0]), .sec_tens(st[0]), .sec_ones(so[0]),
    .running(run_o[0]), .done(done_o[0]), .expired(exp_o[0]), .warn(warn_o[0]));

  game_countdown #(.INIT_MIN(1), .INIT_SEC(0), .WARN_SEC(10)) u1 (
    .clk(clk), .rst(rst[1]), .tick_1s(tick[1]), .start(start[1]), .pause(pause[1]),
    .min_bcd(mb[1]), .sec_tens(st[1]), .sec_ones(so[1]),
    .running(run_o[1]), .done(done_o[1]), .expired(exp_o[1]), .warn(warn_o[1]));

  game_countdown #(.INIT_MIN(0), .INIT_SEC(5), .WARN_SEC(10)) u2 (
    .clk(clk), .rst(rst[2]), .tick_1s(tick[2]), .start(start[2]), .pause(pause[2]),
    .min_bcd(mb[2]), .sec_tens(st[2]), .sec_ones(so[2]),
    .running(run_o[2]), .done(done_o[2]), .expired(exp_o[2]), .warn(warn_o[2]));

  game_countdown #(.INIT_MIN(0), .INIT_SEC(0), .WARN_SEC(10)) u3 (
    .clk(clk), .rst(rst[3]), .tick_1s(tick[3]), .start(start[3]), .pause(pause[3]),
    .min_bcd(mb[3]), .sec_tens(st[3]), .sec_ones(so[3]),
    .running(run_o[3]), .done(done_o[3]), .expired(exp_o[3]), .warn(warn_o[3]));

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due at this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL stale dut%0d cyc%0d: expectation not checked in time (now %0d)", e.id, e.cyc, cyc);
      end else if ({mb[e.id], st[e.id], so[e.id], run_o[e.id], done_o[e.id], exp_o[e.id], warn_o[e.id]} !==
                   {e.m, e.t, e.o, e.r, e.d, e.x, e.w}) begin
        failures++;
        $display("FAIL dut%0d cyc%0d: got %0h:%0h%0h run=%b done=%b exp=%b warn=%b, want %0h:%0h%0h run=%b done=%b exp=%b warn=%b",
                 e.id, cyc, mb[e.id], st[e.id], so[e.id], run_o[e.id], done_o[e.id], exp_o[e.id], warn_o[e.id],
                 e.m, e.t, e.o, e.r, e.d, e.x, e.w);
      end
    end
  end

  // Queue the outputs expected after the next clock edge.
  task automatic ck(input int id, input int m, input int t, input int o,
                    input bit r, input bit d, input bit x, input bit w);
    exp_t n;
    n.id = id; n.cyc = cyc + 1;
    n.m = 4'(m); n.t = 4'(t); n.o = 4'(o);
    n.r = r; n.d = d; n.x = x;
`ifdef GAME_COUNTDOWN_WARN_EN
    n.w = w;
`else
    n.w = 1'b0;
`endif
    q.push_back(n);
  endtask

  // Drive one cycle of inputs for one instance (called right after negedge).
  task automatic step(input int id, input bit r, input bit s, input bit p, input bit t);
    rst[id] = r; start[id] = s; pause[id] = p; tick[id] = t;
    @(negedge clk);
    rst[id] = 1'b0; start[id] = 1'b0; pause[id] = 1'b0; tick[id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem;
    rst = 4'h0; start = 4'h0; pause = 4'h0; tick = 4'h0;
    @(negedge clk);
    // Reset all instances: IDLE with load value, flags low.
    rst = 4'hf;
    ck(0, 0, 1, 2, 0, 0, 0, 0);
    ck(1, 1, 0, 0, 0, 0, 0, 0);
    ck(2, 0, 0, 5, 0, 0, 0, 0);
    ck(3, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 4'h0;

    // dut0 (0:12): IDLE ignores tick/pause, count-down with borrow, warn window.
    ck(0, 0, 1, 2, 0, 0, 0, 0); step(0, 0, 0, 1, 1);
    ck(0, 0, 1, 2, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    ck(0, 0, 1, 2, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    ck(0, 0, 1, 1, 1, 0, 0, 0); step(0, 0, 0, 0, 1);
    ck(0, 0, 1, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 1);
    ck(0, 0, 0, 9, 1, 0, 0, 1); step(0, 0, 0, 0, 1);
    for (int k = 8; k >= 1; k--) begin
      ck(0, 0, 0, k, 1, 0, 0, 1); step(0, 0, 0, 0, 1);
    end
    ck(0, 0, 0, 0, 0, 1, 1, 0); step(0, 0, 0, 0, 1);
    ck(0, 0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    ck(0, 0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 1, 1);

    // dut1 (1:00): run to 0:30, reset mid-count, full run to DONE, reload.
    ck(1, 1, 0, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      rem = 60 - k;
      ck(1, rem / 60, (rem % 60) / 10, rem % 10, 1, 0, 0, rem <= 10);
      step(1, 0, 0, 0, 1);
    end
    ck(1, 1, 0, 0, 0, 0, 0, 0); step(1, 1, 1, 0, 1);
    ck(1, 1, 0, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      rem = 60 - k;
      if (rem == 0) ck(1, 0, 0, 0, 0, 1, 1, 0);
      else          ck(1, rem / 60, (rem % 60) / 10, rem % 10, 1, 0, 0, rem <= 10);
      step(1, 0, 0, 0, 1);
    end
    ck(1, 0, 0, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
    ck(1, 0, 0, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 1);
    ck(1, 0, 0, 0, 0, 1, 0, 0); step(1, 0, 0, 1, 0);
    ck(1, 1, 0, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
    ck(1, 1, 0, 0, 0, 0, 0, 0); step(1, 0, 1, 1, 0);

    // dut2 (0:05): pause freezes count, resume, tick+pause together, DONE wins.
    ck(2, 0, 0, 5, 0, 0, 0, 0); step(2, 0, 0, 1, 1);
    ck(2, 0, 0, 5, 1, 0, 0, 1); step(2, 0, 1, 0, 0);
    ck(2, 0, 0, 4, 1, 0, 0, 1); step(2, 0, 0, 0, 1);
    ck(2, 0, 0, 3, 1, 0, 0, 1); step(2, 0, 0, 0, 1);
    ck(2, 0, 0, 3, 0, 0, 0, 1); step(2, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      ck(2, 0, 0, 3, 0, 0, 0, 1); step(2, 0, 0, 0, 1);
    end
    ck(2, 0, 0, 3, 1, 0, 0, 1); step(2, 0, 0, 1, 0);
    ck(2, 0, 0, 2, 1, 0, 0, 1); step(2, 0, 0, 0, 1);
    ck(2, 0, 0, 1, 0, 0, 0, 1); step(2, 0, 0, 1, 1);
    ck(2, 0, 0, 1, 1, 0, 0, 1); step(2, 0, 1, 0, 0);
    ck(2, 0, 0, 0, 0, 1, 1, 0); step(2, 0, 0, 1, 1);
    ck(2, 0, 0, 0, 0, 1, 0, 0); step(2, 0, 0, 0, 0);

    // dut3 (0:00): start goes straight to DONE, single expired pulse, reset in DONE.
    ck(3, 0, 0, 0, 0, 0, 0, 0); step(3, 0, 0, 1, 1);
    ck(3, 0, 0, 0, 0, 1, 1, 0); step(3, 0, 1, 1, 0);
    ck(3, 0, 0, 0, 0, 1, 0, 0); step(3, 0, 1, 0, 0);
    ck(3, 0, 0, 0, 0, 1, 0, 0); step(3, 0, 0, 0, 0);
    ck(3, 0, 0, 0, 0, 0, 0, 0); step(3, 1, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 Parameter INIT_MIN, default 3: minutes loaded on reset/start, range 0..9.
REQ-002 Parameter INIT_SEC, default 0: seconds loaded on reset/start, range 0..59.
REQ-003 Parameter WARN_SEC, default 10: warning threshold in total seconds, range 1..59.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick_1s  in  1  one-cycle strobe, one per second (from counter_1s tick logic), synchronous to clk.
REQ-007 start  in  1  one-cycle command: load and run / resume.
REQ-008 pause  in  1  one-cycle command: toggle RUN/PAUSED.
REQ-009 min_bcd  out  4  remaining minutes, BCD 0..9.
REQ-010 sec_tens  out  4  remaining seconds tens digit, BCD 0..5.
REQ-011 sec_ones  out  4  remaining seconds ones digit, BCD 0..9.
REQ-012 running  out  1  high while state is RUN.
REQ-013 done  out  1  high while state is DONE.
REQ-014 expired  out  1  one-cycle pulse on entry to DONE.
REQ-015 warn  out  1  low-time warning (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-017 IDLE: start -> load INIT_MIN:INIT_SEC, go RUN; tick_1s and pause ignored.
REQ-018 RUN: tick_1s -> decrement count by one second; outputs show new value the cycle after tick_1s is high.
REQ-019 Decrement: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_bcd decrements on borrow; no digit ever leaves BCD range.
REQ-020 RUN: tick_1s at 0:01 -> count 0:00, state DONE, expired high for exactly that next cycle.
REQ-021 RUN: pause -> PAUSED; start ignored in RUN.
REQ-022 Simultaneous tick_1s and pause in RUN: decrement applied AND state goes PAUSED (or DONE if count reaches 0:00; DONE wins).
REQ-023 PAUSED: pause or start -> RUN without reload; tick_1s ignored; count frozen.
REQ-024 DONE: count held at 0:00, done high; start -> reload INIT value, RUN; tick_1s and pause ignored.
REQ-025 start with INIT value 0:00 -> DONE directly, expired pulses once; never enters RUN.
REQ-026 Simultaneous start and pause: start takes priority in IDLE/DONE/PAUSED; in RUN pause is acted on.
REQ-027 expired SHALL never be high for two consecutive cycles.

Reset
REQ-028 rst sampled on clk rising edge, overrides all other inputs, including mid-count and during DONE.
REQ-029 After reset: state IDLE, min_bcd=INIT_MIN, sec_tens/sec_ones=INIT_SEC digits, running=0, done=0, expired=0, warn=0.

Configuration
REQ-030 Macro GAME_COUNTDOWN_WARN_EN defined: warn=1 while state is RUN or PAUSED and remaining total seconds <= WARN_SEC and > 0; registered, updates same cycle as count.
REQ-031 Macro GAME_COUNTDOWN_WARN_EN undefined: warn tied 0, threshold compare logic absent; all other behaviour identical.

Verification
REQ-032 INIT 0:12, rst, start, 3 ticks -> 0:09; sec_ones 0 -> 9 borrow shown 0:10 -> 0:09.
REQ-033 INIT 1:00, start, 1 tick -> 0:59 next cycle; 59 more ticks -> 0:00, done=1, expired exactly one cycle, further ticks no change.
REQ-034 INIT 0:05, start, 2 ticks, pause, 4 ticks, pause, 1 tick -> 0:02, running=1; frozen at 0:03 while PAUSED.
REQ-035 RUN at 0:01, tick_1s and pause same cycle -> 0:00, DONE, expired=1, not PAUSED.
REQ-036 RUN at 0:30, rst high one cycle -> IDLE, INIT value, all flags 0 next cycle; DONE then start -> reload, running=1.
REQ-037 WARN_EN defined, WARN_SEC=10, INIT 0:12: warn=0 at 0:11, 1 at 0:10 through 0:01, 0 at DONE; WARN_EN undefined -> warn always 0.
